// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider and its rate-path users.
package div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CALC  = 2'd1;
  localparam state_t ST_ROUND = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  localparam int DEF_WIDTH = 8;

  // BPM = K_BPM / beat_period, for a 250 Hz beat-period tick (60 * 250).
  localparam int unsigned K_BPM = 15000;

endpackage

// File: rtl/trial_subtractor.sv
// Combinational (W+1)-bit trial subtraction A-B with borrow-out for the restoring divider.
module trial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  output logic [WIDTH:0] diff_o,
  output logic           borrow_o
);

  assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with START/DONE handshake.
// Optional round-to-nearest quotient stage enabled by defining DIV_ROUND_EN.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  // dvd_q shifts the dividend out MSB-first while quotient bits shift in at the LSB.
  logic [WIDTH-1:0] acc_q, acc_d, dvd_q, dvd_d, dsr_q, dsr_d;

  logic [WIDTH:0]   sub_a, sub_diff, sel_rem;
  logic             sub_borrow;
  logic [WIDTH-1:0] step_rem, step_q;
  logic             unused_sel_msb;

  // acc' needs WIDTH+1 bits: 2*acc+1 can exceed WIDTH bits when the divisor is large.
  assign sub_a = {acc_q, dvd_q[WIDTH-1]};

  trial_subtractor #(.WIDTH(WIDTH)) u_trial_sub (
    .a_i      (sub_a),
    .b_i      ({1'b0, dsr_q}),
    .diff_o   (sub_diff),
    .borrow_o (sub_borrow)
  );

  assign sel_rem        = sub_borrow ? sub_a : sub_diff;
  assign step_rem       = sel_rem[WIDTH-1:0];
  assign step_q         = {dvd_q[WIDTH-2:0], ~sub_borrow};
  assign unused_sel_msb = sel_rem[WIDTH];

`ifdef DIV_ROUND_EN
  function automatic logic [WIDTH-1:0] round_quot(input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] d);
    if (({r, 1'b0} >= {1'b0, d}) && (q != {WIDTH{1'b1}})) return q + 1'b1;
    return q;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d = '0;
          dvd_d = dividend_i;
          dsr_d = divisor_i;
          cnt_d = CNT_W'(WIDTH - 1);
          if (divisor_i == '0) begin
            state_d = ST_FIN;
            quot_d  = '1;
            rem_d   = dividend_i;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_rem;
        dvd_d = step_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
`ifdef DIV_ROUND_EN
          state_d = ST_ROUND;
`else
          state_d = ST_FIN;
          quot_d  = step_q;
          rem_d   = step_rem;
          dz_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`endif
        end
      end
`ifdef DIV_ROUND_EN
      ST_ROUND: begin
        state_d = ST_FIN;
        quot_d  = round_quot(dvd_q, acc_q, dsr_q);
        rem_d   = acc_q;
        dz_d    = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // Working datapath registers are always overwritten on an accepted START.
  always_ff @(posedge clk_i) begin
    acc_q <= acc_d;
    dvd_q <= dvd_d;
    dsr_q <= dsr_d;
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dz_o        = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=8), truncating or DIV_ROUND_EN build.
module tb_seq_divider;

  localparam int W = 8;
`ifdef DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int LAT = W + 1 + RND;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, dz;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .busy_o      (busy),
    .done_o      (done),
    .dz_o        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input int a, input int b);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Launch one divide, wait for DONE, check latency, BUSY profile and results.
  // glitch>0 pulses START with 9/9 at that cycle and leaves those operands applied.
  task automatic run_op(input string tag, input int a, input int b, input int q_trunc,
                        input int q_round, input int r_exp, input int dz_exp,
                        input int lat_exp, input int glitch);
    int k;
    int busy_bad;
    bit seen;
    launch(a, b);
    k = 0; busy_bad = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (glitch != 0 && k == glitch) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
      end
      if (glitch != 0 && k == glitch + 1) start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
      else if (busy !== 1'b1) busy_bad++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    chk({tag, "_latency"}, k, lat_exp);
    chk({tag, "_busy_before_done"}, busy_bad, 0);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_quotient"}, quotient, (RND != 0) ? q_round : q_trunc);
    chk({tag, "_remainder"}, remainder, r_exp);
    chk({tag, "_dz"}, dz, dz_exp);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("d100_7",   100, 7,  14, 14, 2,   0, LAT, 0);
    run_op("d200_0",   200, 0, 255, 255, 200, 1, 1,   0);
    run_op("d255_1",   255, 1, 255, 255, 0,   0, LAT, 0);
    run_op("d0_5",       0, 5,   0, 0,   0,   0, LAT, 0);
    run_op("d50_3_ign", 50, 3,  16, 17,  2,   0, LAT, 3);
    run_op("d255_255", 255, 255, 1, 1,   0,   0, LAT, 0);
    run_op("d7_9",       7, 9,   0, 1,   7,   0, LAT, 0);
    run_op("d255_200", 255, 200, 1, 1,   55,  0, LAT, 0);
    run_op("d100_8",   100, 8,  12, 13,  4,   0, LAT, 0);
    run_op("d255_2",   255, 2, 127, 128, 1,   0, LAT, 0);
    run_op("d9_0",       9, 0, 255, 255, 9,   1, 1,   0);

    // Abort 100/7 mid-computation with an asynchronous reset.
    launch(100, 7);
    repeat (3) @(negedge clk);
    chk("pre_rst_quotient_held", quotient, 255);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_quotient", quotient, 0);
    chk("midop_rst_remainder", remainder, 0);
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_done", done, 0);
    chk("midop_rst_dz", dz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    chk("after_rst_idle", dones, 0);
    run_op("d7_2_after_rst", 7, 2, 3, 4, 1, 0, LAT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
